// File: rtl/reg_file_scoreboard_if.sv
// Decode/writeback bus of the scoreboarded MIPS register file.
// master = pipeline side (decode + writeback), slave = register file.
interface reg_file_scoreboard_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
);
  logic [4:0]                 ReadRegister1;
  logic [4:0]                 ReadRegister2;
  logic                       ReadValid1;
  logic                       ReadValid2;
  logic [DATA_WIDTH-1:0]      ReadData1;
  logic [DATA_WIDTH-1:0]      ReadData2;
  logic [4:0]                 WriteRegister;
  logic [DATA_WIDTH-1:0]      WriteData;
  logic                       RegWrite;
  logic                       IssueValid;
  logic [4:0]                 IssueDest;
  logic                       Stall;
  logic [31:0]                PendingMask;
  logic [STALL_CNT_WIDTH-1:0] StallCount;

  modport master (
    output ReadRegister1, ReadRegister2, ReadValid1, ReadValid2,
    output WriteRegister, WriteData, RegWrite, IssueValid, IssueDest,
    input  ReadData1, ReadData2, Stall, PendingMask, StallCount
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, ReadValid1, ReadValid2,
    input  WriteRegister, WriteData, RegWrite, IssueValid, IssueDest,
    output ReadData1, ReadData2, Stall, PendingMask, StallCount
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// MIPS 32x32 register file with pending-write scoreboard and saturating stall counter.
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback forwarding onto the read ports.
module reg_file_scoreboard #(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic                  Clk,
  input logic                  Rst_n,
  reg_file_scoreboard_if.slave rf
);

  logic [DATA_WIDTH-1:0]      r_regs [32];
  logic [31:1]                r_pending;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  logic [31:0]           w_pend_mask;
  logic                  w_wr_en;
  logic                  w_byp1;
  logic                  w_byp2;
  logic                  w_raw1;
  logic                  w_raw2;
  logic                  w_waw;
  logic                  w_stall;
  logic                  w_issue_en;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  assign w_pend_mask = {r_pending, 1'b0};
  assign w_wr_en     = rf.RegWrite && (rf.WriteRegister != 5'd0);

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_wr_en && (rf.WriteRegister == rf.ReadRegister1);
  assign w_byp2 = w_wr_en && (rf.WriteRegister == rf.ReadRegister2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    w_rd1 = (rf.ReadRegister1 == 5'd0) ? '0 : r_regs[rf.ReadRegister1];
    w_rd2 = (rf.ReadRegister2 == 5'd0) ? '0 : r_regs[rf.ReadRegister2];
    if (w_byp1) w_rd1 = rf.WriteData;
    if (w_byp2) w_rd2 = rf.WriteData;
  end

  // A writeback to the issue destination this cycle retires the old producer,
  // so the new issue is not a WAW hazard.
  assign w_raw1     = rf.ReadValid1 && w_pend_mask[rf.ReadRegister1] && !w_byp1;
  assign w_raw2     = rf.ReadValid2 && w_pend_mask[rf.ReadRegister2] && !w_byp2;
  assign w_waw      = rf.IssueValid && w_pend_mask[rf.IssueDest] &&
                      !(rf.RegWrite && (rf.WriteRegister == rf.IssueDest));
  assign w_stall    = w_raw1 || w_raw2 || w_waw;
  assign w_issue_en = rf.IssueValid && !w_stall && (rf.IssueDest != 5'd0);

  assign rf.ReadData1   = w_rd1;
  assign rf.ReadData2   = w_rd2;
  assign rf.Stall       = w_stall;
  assign rf.PendingMask = w_pend_mask;
  assign rf.StallCount  = r_stall_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[rf.WriteRegister] <= rf.WriteData;
    end
  end

  // Issue beats writeback on the same register: the newer producer owns it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pending <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_issue_en && (rf.IssueDest == 5'(i)))
          r_pending[i] <= 1'b1;
        else if (w_wr_en && (rf.WriteRegister == 5'(i)))
          r_pending[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench for reg_file_scoreboard: directed + random stimulus against a
// behavioural register-file model; follows REGFILE_BYPASS_EN like the design.
module tb_reg_file_scoreboard;
  localparam int DW = 32;
  localparam int SW = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] stall;
    logic [31:0] pmask;
    logic [31:0] scnt;
  } exp_t;

  logic Clk;
  logic Rst_n;
  reg_file_scoreboard_if #(.DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)) rf ();

  reg_file_scoreboard #(.DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .rf    (rf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int unsigned m_scnt;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per checked cycle, compared mid-cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("ReadData1",   rf.ReadData1,   e.rd1);
      cmp("ReadData2",   rf.ReadData2,   e.rd2);
      cmp("Stall",       32'(rf.Stall),  e.stall);
      cmp("PendingMask", rf.PendingMask, e.pmask);
      cmp("StallCount",  32'(rf.StallCount), e.scnt);
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_scnt = 0;
  endfunction

  task automatic set_in(input bit rv1, input int ra1, input bit rv2, input int ra2,
                        input bit we, input int wa, input logic [31:0] wd,
                        input bit iv, input int id);
    rf.ReadValid1 = rv1; rf.ReadRegister1 = 5'(ra1);
    rf.ReadValid2 = rv2; rf.ReadRegister2 = 5'(ra2);
    rf.RegWrite = we; rf.WriteRegister = 5'(wa); rf.WriteData = wd;
    rf.IssueValid = iv; rf.IssueDest = 5'(id);
  endtask

  // Predict this cycle's outputs from the model, then advance the model at the edge.
  task automatic do_cycle(input bit chk);
    exp_t e;
    bit   wr_ok, hit1, hit2, stall;
    int   a1, a2, wa, id;
    a1 = rf.ReadRegister1; a2 = rf.ReadRegister2;
    wa = rf.WriteRegister; id = rf.IssueDest;
    wr_ok = rf.RegWrite && wa != 0;
    hit1  = BYP && wr_ok && wa == a1;
    hit2  = BYP && wr_ok && wa == a2;
    stall = (rf.ReadValid1 && m_pend[a1] && !hit1) ||
            (rf.ReadValid2 && m_pend[a2] && !hit2) ||
            (rf.IssueValid && m_pend[id] && !(rf.RegWrite && wa == id));
    e.rd1   = hit1 ? rf.WriteData : m_regs[a1];
    e.rd2   = hit2 ? rf.WriteData : m_regs[a2];
    e.stall = 32'(stall);
    e.pmask = '0;
    for (int i = 0; i < 32; i++) e.pmask[i] = m_pend[i];
    e.scnt  = m_scnt;
    if (chk) exp_q.push_back(e);
    @(posedge Clk);
    if (Rst_n) begin
      if (wr_ok) begin
        m_regs[wa] = rf.WriteData;
        m_pend[wa] = 1'b0;
      end
      if (rf.IssueValid && !stall && id != 0) m_pend[id] = 1'b1;
      if (stall && m_scnt < 32'hFFFF) m_scnt++;
    end
    #1;
  endtask

  initial begin
    Rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, '0, 0, 0);
    model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Reset state
    set_in(1, 8, 1, 9, 0, 0, '0, 0, 0);
    do_cycle(1);

    // Write sweep then paired reads
    for (int i = 0; i < 18; i++) begin
      set_in(1, 8, 0, 25, 1, 8 + i, 32'h100 + i, 0, 0);
      do_cycle(1);
    end
    for (int k = 0; k < 9; k++) begin
      set_in(1, 8 + 2 * k, 1, 9 + 2 * k, 0, 0, '0, 0, 0);
      do_cycle(1);
    end
    set_in(0, 0, 0, 0, 1, 0, 32'd77, 0, 0);
    do_cycle(1);
    set_in(1, 0, 1, 0, 0, 0, '0, 0, 0);
    do_cycle(1);

    // RAW stall resolved by writeback
    set_in(0, 0, 0, 0, 0, 0, '0, 1, 10);
    do_cycle(1);
    for (int i = 0; i < 3; i++) begin
      set_in(1, 10, 0, 0, 0, 0, '0, 0, 0);
      do_cycle(1);
    end
    set_in(1, 10, 0, 0, 1, 10, 32'hDEAD, 0, 0);
    do_cycle(1);
    set_in(1, 10, 0, 0, 0, 0, '0, 0, 0);
    do_cycle(1);

    // Unused operand does not stall
    set_in(0, 0, 0, 0, 0, 0, '0, 1, 12);
    do_cycle(1);
    set_in(0, 0, 0, 12, 0, 0, '0, 0, 0);
    do_cycle(1);
    set_in(0, 0, 1, 12, 0, 0, '0, 0, 0);
    do_cycle(1);

    // WAW stall, then simultaneous write + issue
    set_in(0, 0, 0, 0, 0, 0, '0, 1, 5);
    do_cycle(1);
    set_in(0, 0, 0, 0, 0, 0, '0, 1, 5);
    do_cycle(1);
    set_in(0, 0, 0, 0, 1, 5, 32'd3, 1, 5);
    do_cycle(1);
    set_in(0, 5, 0, 0, 0, 0, '0, 0, 0);
    do_cycle(1);

    // Issue to r0 is ignored
    set_in(1, 0, 0, 0, 0, 0, '0, 1, 0);
    do_cycle(1);
    set_in(1, 0, 0, 0, 0, 0, '0, 0, 0);
    do_cycle(1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), $urandom_range(0, 31),
             1'($urandom_range(0, 1)), $urandom_range(0, 31),
             ($urandom_range(0, 2) != 0), $urandom_range(0, 31), $urandom,
             ($urandom_range(0, 3) == 0), $urandom_range(0, 31));
      do_cycle(1);
    end

    // Saturation: hold a RAW stall on r7 past the counter range
    set_in(0, 0, 0, 0, 1, 7, 32'h77, 0, 0);
    do_cycle(1);
    set_in(0, 0, 0, 0, 0, 0, '0, 1, 7);
    do_cycle(1);
    set_in(1, 7, 0, 0, 0, 0, '0, 0, 0);
    do_cycle(1);
    for (int n = 0; n < 66000; n++) do_cycle(0);
    do_cycle(1);

    // Asynchronous reset pulse between edges, checked while still asserted
    Rst_n = 1'b0;
    model_reset();
    set_in(1, 7, 1, 10, 0, 0, '0, 0, 0);
    do_cycle_in_reset();
    set_in(1, 7, 1, 10, 0, 0, '0, 0, 0);
    do_cycle(1);

    @(negedge Clk); #1;
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  task automatic do_cycle_in_reset();
    exp_t e;
    e.rd1 = '0; e.rd2 = '0; e.stall = '0; e.pmask = '0; e.scnt = '0;
    exp_q.push_back(e);
    @(negedge Clk);
    #1;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

endmodule
